// File: rtl/voxel_gpu_pkg.sv
// Shared types and constants for the frame-buffer swap sequencer and its DMA master port.
package voxel_gpu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned S_ADDR_W   = 8;
    localparam int unsigned M_ADDR_W   = 2;
    localparam int unsigned POLL_CNT_W = 21;
    localparam int unsigned GAP_CNT_W  = 16;

    typedef logic [2:0] swap_state_t;

    localparam swap_state_t ST_IDLE    = 3'd0;
    localparam swap_state_t ST_WR_BACK = 3'd1;
    localparam swap_state_t ST_WR_SWAP = 3'd2;
    localparam swap_state_t ST_GAP     = 3'd3;
    localparam swap_state_t ST_RD_STAT = 3'd4;
    localparam swap_state_t ST_DONE    = 3'd5;

    localparam logic [S_ADDR_W-1:0] REG_BUF_A  = 8'h00;
    localparam logic [S_ADDR_W-1:0] REG_BUF_B  = 8'h01;
    localparam logic [S_ADDR_W-1:0] REG_CTRL   = 8'h02;
    localparam logic [S_ADDR_W-1:0] REG_STATUS = 8'h03;

    localparam logic [M_ADDR_W-1:0] DMA_BUFFER     = 2'd0;
    localparam logic [M_ADDR_W-1:0] DMA_BACKBUFFER = 2'd1;
    localparam logic [M_ADDR_W-1:0] DMA_STATUS     = 2'd3;

    localparam int unsigned CTRL_SWAP    = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FRONT   = 1;
    localparam int unsigned STAT_DONE    = 2;
    localparam int unsigned STAT_TIMEOUT = 3;
    localparam int unsigned STAT_PENDING = 4;

    // One master access as issued by the sequencer.
    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [M_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]   data;
    } dma_req_t;

    function automatic logic [POLL_CNT_W-1:0] sat_inc(input logic [POLL_CNT_W-1:0] v);
        return (&v) ? v : v + POLL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/avalon_master_port.sv
// Avalon-MM master holding register: keeps strobe, address and data steady until the
// slave drops waitrequest, then releases the strobe on the following edge.
module avalon_master_port
    import voxel_gpu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  dma_req_t            req,
    output logic [M_ADDR_W-1:0] m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest,
    output logic                accepted_c,
    output logic [DATA_W-1:0]   rdata_c
);

    dma_req_t cur_q;
    dma_req_t cur_d;

    assign accepted_c  = (cur_q.rd | cur_q.wr) & ~m_waitrequest;
    assign rdata_c     = m_readdata;
    assign m_address   = cur_q.addr;
    assign m_read      = cur_q.rd;
    assign m_write     = cur_q.wr;
    assign m_writedata = cur_q.data;

    // A new request may land in the same cycle the previous one is accepted.
    always_comb begin
        cur_d = cur_q;
        if (accepted_c) begin
            cur_d.rd = 1'b0;
            cur_d.wr = 1'b0;
        end
        if (req.rd || req.wr) begin
            cur_d = req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_q <= '0;
        end else begin
            cur_q <= cur_d;
        end
    end

endmodule

// File: rtl/buffer_swap_controller.sv
// Double-buffer swap sequencer: programs the pixel-buffer DMA back buffer, triggers a
// swap, polls until vsync completion, tracks the front buffer and raises an interrupt.
module buffer_swap_controller
    import voxel_gpu_pkg::*;
#(
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned POLL_LIMIT = 2000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [S_ADDR_W-1:0] s1_address,
    output logic [DATA_W-1:0]   s1_readdata,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic                s1_write,
    output logic                s1_waitrequest,
    output logic [M_ADDR_W-1:0] m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest,
    output logic                interrupt_sender_irq
);

    swap_state_t           state_q, state_d;
    logic [DATA_W-1:0]     buf_a_q, buf_a_d;
    logic [DATA_W-1:0]     buf_b_q, buf_b_d;
    logic [DATA_W-1:0]     target_q, target_d;
    logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic                  irq_en_q, irq_en_d;
    logic                  front_q, front_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  pending_q, pending_d;
    logic                  irq_q, irq_d;

    dma_req_t              req;
    logic                  dma_accepted_c;
    logic [DATA_W-1:0]     dma_rdata_c;
    logic                  swap_wr_c;
    logic                  unused_rdata;

    assign s1_waitrequest       = 1'b0;
    assign interrupt_sender_irq = irq_q;
    assign swap_wr_c            = s1_write && (s1_address == REG_CTRL) && s1_writedata[CTRL_SWAP];
    assign unused_rdata         = ^dma_rdata_c[DATA_W-1:1];

    avalon_master_port u_master (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .accepted_c    (dma_accepted_c),
        .rdata_c       (dma_rdata_c)
    );

    always_comb begin
        s1_readdata = '0;
        case (s1_address)
            REG_BUF_A:  s1_readdata = buf_a_q;
            REG_BUF_B:  s1_readdata = buf_b_q;
            REG_CTRL:   s1_readdata[CTRL_IRQ_EN] = irq_en_q;
            REG_STATUS: begin
                s1_readdata[STAT_BUSY]    = (state_q != ST_IDLE);
                s1_readdata[STAT_FRONT]   = front_q;
                s1_readdata[STAT_DONE]    = done_q;
                s1_readdata[STAT_TIMEOUT] = timeout_q;
                s1_readdata[STAT_PENDING] = pending_q;
            end
            default: s1_readdata = '0;
        endcase
    end

    // Register writes first, then sequencer actions, so hardware sets override W1C.
    always_comb begin
        state_d    = state_q;
        buf_a_d    = buf_a_q;
        buf_b_d    = buf_b_q;
        target_d   = target_q;
        gap_cnt_d  = gap_cnt_q;
        poll_cnt_d = poll_cnt_q;
        irq_en_d   = irq_en_q;
        front_d    = front_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        pending_d  = pending_q;
        req        = '0;

        if (s1_write) begin
            case (s1_address)
                REG_BUF_A: buf_a_d  = s1_writedata;
                REG_BUF_B: buf_b_d  = s1_writedata;
                REG_CTRL:  irq_en_d = s1_writedata[CTRL_IRQ_EN];
                REG_STATUS: begin
                    if (s1_writedata[STAT_DONE])    done_d    = 1'b0;
                    if (s1_writedata[STAT_TIMEOUT]) timeout_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (swap_wr_c && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pending_q || swap_wr_c) begin
                    target_d  = front_q ? buf_a_q : buf_b_q;
                    pending_d = 1'b0;
                    req       = '{rd: 1'b0, wr: 1'b1, addr: DMA_BACKBUFFER, data: target_d};
                    state_d   = ST_WR_BACK;
                end
            end
            ST_WR_BACK: begin
                if (dma_accepted_c) begin
                    req     = '{rd: 1'b0, wr: 1'b1, addr: DMA_BUFFER, data: DATA_W'(1)};
                    state_d = ST_WR_SWAP;
                end
            end
            ST_WR_SWAP: begin
                if (dma_accepted_c) begin
                    poll_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_CNT_W'(POLL_GAP - 1)) begin
                    req     = '{rd: 1'b1, wr: 1'b0, addr: DMA_STATUS, data: target_q};
                    state_d = ST_RD_STAT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
                end
            end
            ST_RD_STAT: begin
                if (dma_accepted_c) begin
                    poll_cnt_d = sat_inc(poll_cnt_q);
                    if (!dma_rdata_c[0]) begin
                        state_d = ST_DONE;
                    end else if (poll_cnt_d >= POLL_CNT_W'(POLL_LIMIT)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_DONE: begin
                front_d = ~front_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        irq_d = irq_en_d & (done_d | timeout_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            buf_a_q    <= '0;
            buf_b_q    <= '0;
            target_q   <= '0;
            gap_cnt_q  <= '0;
            poll_cnt_q <= '0;
            irq_en_q   <= 1'b0;
            front_q    <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            target_q   <= target_d;
            gap_cnt_q  <= gap_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            irq_en_q   <= irq_en_d;
            front_q    <= front_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
        end
    end

endmodule
